redun_carry_resolve: RTL and testbench

- Sequential converter from redundant-form field elements (NUM_WRDS words, each WRD_BITS+1 bits) to plain binary of NUM_WRDS*WRD_BITS bits.
- Resolves carries WRDS_PER_CYC words per cycle, so the carry chain length trades against latency.
- Also produces the overflow flag and a speculative-carry flag.
- Sits at the output of the redundant Montgomery squaring pipeline, ahead of result readout and from_mont conversion.

---
 rtl/redun_carry_resolve.sv | 137 +++++++++++++
 tb/tb_redun_carry_resolve.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_carry_resolve.sv
// Redundant-to-binary carry resolver. It latches one redundant element, ripples its
// carries WRDS_PER_CYC words per beat, and holds the result until downstream takes it.
module redun_carry_resolve #(
  parameter int WRD_BITS     = 32,
  parameter int NUM_WRDS     = 33,
  parameter int WRDS_PER_CYC = 4,
  parameter int SPEC_WRDS    = 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
  input  logic                             i_val,
  output logic                             o_rdy,
  output logic [NUM_WRDS*WRD_BITS-1:0]     o_dat,
  output logic                             o_ovf,
  output logic                             o_spec,
  output logic                             o_val,
  input  logic                             i_rdy
);
  localparam int RW        = WRD_BITS + 1;
  localparam int NUM_BEATS = (NUM_WRDS + WRDS_PER_CYC - 1) / WRDS_PER_CYC;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                       state_q;
  logic [NUM_WRDS*RW-1:0]       in_q;
  logic [NUM_WRDS*WRD_BITS-1:0] res_q;
  logic [NUM_WRDS*WRD_BITS-1:0] res_d;
  logic [CNT_W-1:0]             beat_q;
  logic                         carry_q;
  logic                         carry_d;
  logic                         rdy_q;
  logic                         val_q;
  logic                         ovf_q;
  logic                         spec_q;
  logic                         spec_s;
  logic [NUM_WRDS:0]            tops_s;

  // Speculative-carry flag: any of the top SPEC_WRDS incoming words has an all-ones payload.
  always_comb begin
    spec_s = 1'b0;
    for (int k = NUM_WRDS - SPEC_WRDS; k < NUM_WRDS; k++) begin
      spec_s = spec_s | (&i_dat[k*RW +: WRD_BITS]);
    end
  end

  // tops_s[i] is the carry bit that word i-1 hands to word i; tops_s[NUM_WRDS] leaves the element.
  always_comb begin
    tops_s    = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      tops_s[i+1] = in_q[i*RW + WRD_BITS];
    end
  end

  // One beat of the carry chain; the partial last beat simply skips indices past the element.
  always_comb begin
    logic [WRD_BITS:0] t;
    logic              c;
    int                idx;
    res_d = res_q;
    c     = carry_q;
    t     = '0;
    idx   = 0;
    for (int j = 0; j < WRDS_PER_CYC; j++) begin
      idx = int'(beat_q) * WRDS_PER_CYC + j;
      if (idx < NUM_WRDS) begin
        t = {1'b0, in_q[idx*RW +: WRD_BITS]}
          + {{WRD_BITS{1'b0}}, tops_s[idx]}
          + {{WRD_BITS{1'b0}}, c};
        res_d[idx*WRD_BITS +: WRD_BITS] = t[WRD_BITS-1:0];
        c = t[WRD_BITS];
      end else begin
        c = c;
      end
    end
    carry_d = c;
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      in_q    <= '0;
      res_q   <= '0;
      beat_q  <= '0;
      carry_q <= 1'b0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
      ovf_q   <= 1'b0;
      spec_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_val) begin
            in_q    <= i_dat;
            spec_q  <= spec_s;
            carry_q <= 1'b0;
            beat_q  <= '0;
            rdy_q   <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          res_q   <= res_d;
          carry_q <= carry_d;
          beat_q  <= beat_q + CNT_W'(1);
          if (beat_q == LAST_BEAT) begin
            ovf_q   <= tops_s[NUM_WRDS] | carry_d;
            val_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (i_rdy) begin
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_rdy  = rdy_q;
  assign o_val  = val_q;
  assign o_dat  = res_q;
  assign o_ovf  = ovf_q;
  assign o_spec = spec_q;

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Directed and random checks of redun_carry_resolve, five instances differing only in
// words-per-beat, all fed the same stimulus.
module tb_redun_carry_resolve;
  localparam int W  = 32;
  localparam int N  = 33;
  localparam int NI = 5;
  localparam int DW = N * (W + 1);
  localparam int OW = N * W;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dat;
  logic          val;
  logic          rdy_in;
  logic [NI-1:0] o_rdy, o_val, o_ovf, o_spec;
  logic [OW-1:0] o_dat [NI];
  logic [W:0]    wrd [N];

  int n_vec  = 0;
  int n_miss = 0;
  int wpc   [NI] = '{1, 3, 4, 11, 33};
  int beats [NI] = '{33, 11, 9, 3, 1};

  always #5 clk = ~clk;

  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(1), .SPEC_WRDS(1)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy[0]), .o_dat(o_dat[0]),
    .o_ovf(o_ovf[0]), .o_spec(o_spec[0]), .o_val(o_val[0]), .i_rdy(rdy_in));
  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(3), .SPEC_WRDS(1)) u_w3 (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy[1]), .o_dat(o_dat[1]),
    .o_ovf(o_ovf[1]), .o_spec(o_spec[1]), .o_val(o_val[1]), .i_rdy(rdy_in));
  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(4), .SPEC_WRDS(1)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy[2]), .o_dat(o_dat[2]),
    .o_ovf(o_ovf[2]), .o_spec(o_spec[2]), .o_val(o_val[2]), .i_rdy(rdy_in));
  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(11), .SPEC_WRDS(1)) u_w11 (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy[3]), .o_dat(o_dat[3]),
    .o_ovf(o_ovf[3]), .o_spec(o_spec[3]), .o_val(o_val[3]), .i_rdy(rdy_in));
  redun_carry_resolve #(.WRD_BITS(W), .NUM_WRDS(N), .WRDS_PER_CYC(33), .SPEC_WRDS(1)) u_w33 (
    .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy[4]), .o_dat(o_dat[4]),
    .o_ovf(o_ovf[4]), .o_spec(o_spec[4]), .o_val(o_val[4]), .i_rdy(rdy_in));

  function automatic int first_diff(input logic [OW-1:0] a, input logic [OW-1:0] b);
    for (int i = 0; i < N; i++) begin
      if (a[i*W +: W] !== b[i*W +: W]) return i;
    end
    return 0;
  endfunction

  task automatic load_dat();
    for (int i = 0; i < N; i++) dat[i*(W+1) +: W+1] = wrd[i];
  endtask

  // Reference: plain integer sum of the weighted words.
  task automatic model(output logic [OW-1:0] ed, output logic eo, output logic es);
    logic [OW+3:0] acc;
    logic [OW+3:0] term;
    acc = '0;
    for (int i = 0; i < N; i++) begin
      term      = '0;
      term[W:0] = wrd[i];
      acc       = acc + (term << (i * W));
    end
    ed = acc[OW-1:0];
    eo = |acc[OW+3:OW];
    es = &wrd[N-1][W-1:0];
  endtask

  task automatic run_vec(input logic [OW-1:0] ed, input logic eo, input logic es, input string nm);
    logic [NI-1:0] seen;
    int            lat [NI];
    int            d;
    seen = '0;
    for (int u = 0; u < NI; u++) lat[u] = 0;
    load_dat();
    val    = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    val = 1'b0;
    dat = ~dat;
    n_vec++;
    if (o_rdy !== 5'b00000) begin
      n_miss++;
      $display("FAIL %s busy_rdy: got %b want 00000", nm, o_rdy);
    end
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < NI; u++) begin
        if (seen[u] && lat[u] == k - 1) begin
          n_vec++;
          if (o_rdy[u] !== 1'b1 || o_val[u] !== 1'b0) begin
            n_miss++;
            $display("FAIL %s release wpc%0d: rdy/val got %b%b want 10", nm, wpc[u], o_rdy[u], o_val[u]);
          end
        end
        if (o_val[u] === 1'b1 && !seen[u]) begin
          seen[u] = 1'b1;
          lat[u]  = k;
          n_vec++;
          if (k != beats[u]) begin
            n_miss++;
            $display("FAIL %s latency wpc%0d: got %0d want %0d", nm, wpc[u], k, beats[u]);
          end
          n_vec++;
          if (o_dat[u] !== ed || o_ovf[u] !== eo || o_spec[u] !== es) begin
            n_miss++;
            d = first_diff(o_dat[u], ed);
            $display("FAIL %s result wpc%0d: word%0d got %h want %h, ovf got %b want %b, spec got %b want %b",
                     nm, wpc[u], d, o_dat[u][d*W +: W], ed[d*W +: W], o_ovf[u], eo, o_spec[u], es);
          end
        end
      end
    end
    for (int u = 0; u < NI; u++) begin
      n_vec++;
      if (!seen[u]) begin
        n_miss++;
        $display("FAIL %s timeout wpc%0d: o_val got 0 want 1 within 36 cycles", nm, wpc[u]);
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    val    = 1'b0;
    rdy_in = 1'b1;
    dat    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < NI; u++) begin
      n_vec++;
      if (o_rdy[u] !== 1'b1 || o_val[u] !== 1'b0 || o_dat[u] !== '0 || o_ovf[u] !== 1'b0 || o_spec[u] !== 1'b0) begin
        n_miss++;
        $display("FAIL reset wpc%0d: rdy,val,ovf,spec got %b%b%b%b want 1000, dat zero %b",
                 wpc[u], o_rdy[u], o_val[u], o_ovf[u], o_spec[u], o_dat[u] === '0);
      end
    end
  endtask

  task automatic test_zero();
    for (int i = 0; i < N; i++) wrd[i] = '0;
    run_vec('0, 1'b0, 1'b0, "zero");
  endtask

  task automatic test_full_ripple();
    logic [OW-1:0] ed;
    wrd[0] = {1'b1, 32'h0000_0005};
    for (int i = 1; i < N; i++) wrd[i] = {1'b0, 32'hFFFF_FFFF};
    ed = '0;
    ed[W-1:0] = 32'd5;
    run_vec(ed, 1'b1, 1'b1, "ripple");
  endtask

  task automatic test_carry_bits();
    logic [OW-1:0] ed;
    for (int i = 0; i < N; i++) wrd[i] = {1'b1, 32'h0000_0000};
    ed = '0;
    for (int i = 1; i < N; i++) ed[i*W +: W] = 32'd1;
    run_vec(ed, 1'b1, 1'b0, "carrybits");
  endtask

  task automatic test_random();
    logic [OW-1:0] ed;
    logic          eo, es;
    logic [W-1:0]  lo;
    for (int v = 0; v < 500; v++) begin
      for (int i = 0; i < N; i++) begin
        lo     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
        wrd[i] = {1'($urandom_range(0, 1)), lo};
      end
      model(ed, eo, es);
      run_vec(ed, eo, es, "random");
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] ed;
    logic          eo, es;
    int            d;
    for (int i = 0; i < N; i++) wrd[i] = {1'($urandom_range(0, 1)), $urandom()};
    wrd[N-1][W-1:0] = 32'hFFFF_FFFF;
    model(ed, eo, es);
    load_dat();
    val    = 1'b1;
    rdy_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    val = 1'b0;
    dat = ~dat;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      val = (k == 19) ? 1'b1 : 1'b0;
      if (k == 8) begin
        n_vec++;
        if (o_val[2] !== 1'b0) begin
          n_miss++;
          $display("FAIL stall early_val: got %b want 0", o_val[2]);
        end
      end
      if (k >= 9 && k <= 29) begin
        n_vec++;
        if (o_val[2] !== 1'b1 || o_rdy[2] !== 1'b0 || o_dat[2] !== ed || o_ovf[2] !== eo || o_spec[2] !== es) begin
          n_miss++;
          d = first_diff(o_dat[2], ed);
          $display("FAIL stall hold k%0d: val,rdy got %b%b want 10, word%0d got %h want %h, ovf %b/%b spec %b/%b",
                   k, o_val[2], o_rdy[2], d, o_dat[2][d*W +: W], ed[d*W +: W], o_ovf[2], eo, o_spec[2], es);
        end
      end
    end
    for (int u = 0; u < NI; u++) begin
      n_vec++;
      if (o_val[u] !== 1'b1 || o_rdy[u] !== 1'b0 || o_dat[u] !== ed || o_ovf[u] !== eo || o_spec[u] !== es) begin
        n_miss++;
        $display("FAIL stall end wpc%0d: val,rdy got %b%b want 10, dat ok %b, ovf %b/%b spec %b/%b",
                 wpc[u], o_val[u], o_rdy[u], o_dat[u] === ed, o_ovf[u], eo, o_spec[u], es);
      end
    end
    rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < NI; u++) begin
      n_vec++;
      if (o_val[u] !== 1'b0 || o_rdy[u] !== 1'b1) begin
        n_miss++;
        $display("FAIL stall release wpc%0d: val,rdy got %b%b want 01", wpc[u], o_val[u], o_rdy[u]);
      end
    end
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (o_val !== 5'b00000 || o_rdy !== 5'b11111) begin
        n_miss++;
        $display("FAIL stall queued: val got %b want 00000, rdy got %b want 11111", o_val, o_rdy);
      end
    end
  endtask

  task automatic test_reset_mid();
    test_full_ripple_load();
    val    = 1'b1;
    rdy_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    val = 1'b0;
    dat = ~dat;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    val = 1'b0;
    for (int u = 0; u < NI; u++) begin
      n_vec++;
      if (o_rdy[u] !== 1'b1 || o_val[u] !== 1'b0 || o_dat[u] !== '0 || o_ovf[u] !== 1'b0 || o_spec[u] !== 1'b0) begin
        n_miss++;
        $display("FAIL midreset wpc%0d: rdy,val,ovf,spec got %b%b%b%b want 1000, dat zero %b",
                 wpc[u], o_rdy[u], o_val[u], o_ovf[u], o_spec[u], o_dat[u] === '0);
      end
    end
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (o_val !== 5'b00000) begin
        n_miss++;
        $display("FAIL midreset stale_val: got %b want 00000", o_val);
      end
    end
    test_carry_bits();
  endtask

  task automatic test_full_ripple_load();
    wrd[0] = {1'b1, 32'h0000_0005};
    for (int i = 1; i < N; i++) wrd[i] = {1'b0, 32'hFFFF_FFFF};
    load_dat();
  endtask

  initial begin
    test_reset();
    test_zero();
    test_full_ripple();
    test_carry_bits();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
